cnt_seq_monitor: RTL and testbench
==================================

Name: cnt_seq_monitor

Overview:
- Downstream checker for the 3-bit DFF-built sequence counter.
- Samples the counter's 3-bit output, locks onto the fixed 6-state cycle 000→001→011→100→101→111→000, and tracks position.
- Flags illegal codes and out-of-order transitions, counts errors and completed cycles.
- Gives the test environment and top-level glue a single locked/error status for the counter stage.

Parameters:
- CW, 3, width of monitored count.
- SEQ_LEN, 6, number of legal states in the cycle.
- SEQ, {3'b111,3'b101,3'b100,3'b011,3'b001,3'b000}, packed legal sequence; entry i is SEQ[i*CW +: CW], entry 0 is the cycle start.
- LOCK_THRESH, 3, consecutive correct transitions required to lock (1..15).
- CYC_W, 8, width of the completed-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  sample strobe; cnt_in is evaluated only when high.
- cnt_in  in  CW  counter value under test.
- locked  out  1  high while in LOCK state.
- pos  out  3  index (0..SEQ_LEN-1) of the last accepted sample; 0 in HUNT.
- err  out  1  one-cycle pulse on any sequence violation while in LOCK.
- illegal  out  1  one-cycle pulse when a sampled value is not in SEQ (any state).
- err_cnt  out  8  saturating error count (increments with err).
- cycle_done  out  1  one-cycle pulse when SEQ[SEQ_LEN-1] is accepted in LOCK.
- cycle_cnt  out  CYC_W  completed cycles, wraps modulo 2^CYC_W.

Behaviour:
- All outputs are registered and update on the clk edge after the valid sample. Latency is 1 cycle.
- Reset: state=HUNT, match=0, locked=0, pos=0, err=0, illegal=0, err_cnt=0, cycle_done=0, cycle_cnt=0.
- rst overrides valid in the same cycle. Reset mid-operation discards lock and all counts.
- valid=0: state, pos, match and counts hold. Pulses (err, illegal, cycle_done) are 0.
- Lookup: idx(v) is the index i with SEQ[i]==v. Entries are unique; no match means the value is illegal.
- exp is (pos+1) mod SEQ_LEN.
- HUNT, valid:
  - Legal v: go to VERIFY, pos=idx(v), match=0.
  - Illegal v: illegal=1, stay in HUNT.
- VERIFY, valid:
  - v==SEQ[exp]: pos=exp, match+1. When match+1==LOCK_THRESH, go to LOCK.
  - Legal v but wrong: re-anchor, pos=idx(v), match=0, stay in VERIFY.
  - Illegal v: illegal=1, go to HUNT, pos=0.
  - No err pulse in VERIFY.
- LOCK, valid:
  - v==SEQ[exp]: pos=exp. If exp==SEQ_LEN-1, cycle_done=1 and cycle_cnt+1.
  - Wrong legal v: err=1, err_cnt+1 (saturates at 255), go to VERIFY, pos=idx(v), match=0.
  - Illegal v: err=1 and illegal=1, err_cnt+1, go to HUNT, pos=0.
- Repeated value (same as pos) counts as a violation; the counter advances every clock.
- locked falls on the same edge as the err pulse.
- Wrap-around: exp from pos=SEQ_LEN-1 is 0, so 111→000 is a correct transition.
- State encoding is 2-bit; the unused code returns to HUNT.

Test Plan:
- Lock-on:
  - Stimulus: rst 2 cycles, then valid=1 with 000,001,011,100.
  - Response: locked=0 through the 4th sample edge; locked=1 one cycle after 100, pos=3, err_cnt=0.
- Full cycle:
  - Stimulus: continue from lock with 101,111,000,001.
  - Response: cycle_done pulses exactly once, one cycle after 111; cycle_cnt=1; pos after 000 is 0; no err.
- Illegal in LOCK:
  - Stimulus: locked at pos=2 (011), then drive 010.
  - Response: err=1 and illegal=1 for one cycle; err_cnt=1; locked=0; pos=0; next 000 enters VERIFY.
- Out-of-order legal in LOCK:
  - Stimulus: locked at pos=2, then drive 101.
  - Response: err=1, illegal=0, err_cnt+1, locked=0, pos=4; then 111,000,001 relock (3 transitions).
- Valid gaps:
  - Stimulus: locked, valid toggling 1/0 with the correct sequence on valid cycles, cnt_in=010 on valid=0 cycles.
  - Response: no err/illegal, pos advances only on valid.
- Saturation and reset:
  - Stimulus: force 300 LOCK errors (relock between each).
  - Response: err_cnt stays 255.
  - Stimulus: then assert rst while locked with valid=1.
  - Response: next cycle all outputs 0, state HUNT.

Source files
------------

// File: rtl/cnt_seq_monitor.sv
// Checks a 3-bit sequence counter against its fixed 6-state cycle.
// It locks on after enough correct transitions, then flags illegal codes and
// out-of-order steps and counts errors and completed cycles.
module cnt_seq_monitor #(
  parameter int                      CW          = 3,
  parameter int                      SEQ_LEN     = 6,
  parameter logic [SEQ_LEN*CW-1:0]   SEQ         = {3'b111, 3'b101, 3'b100, 3'b011, 3'b001, 3'b000},
  parameter int                      LOCK_THRESH = 3,
  parameter int                      CYC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [CW-1:0]    cnt_in,
  output logic             locked,
  output logic [2:0]       pos,
  output logic             err,
  output logic             illegal,
  output logic [7:0]       err_cnt,
  output logic             cycle_done,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [2:0]       r_pos, w_pos_nx;
  logic [3:0]       r_match, w_match_nx;
  logic             r_locked, r_err, r_illegal, r_cycle_done;
  logic             w_err_nx, w_illegal_nx, w_cycle_done_nx;
  logic [7:0]       r_err_cnt, w_err_cnt_nx;
  logic [CYC_W-1:0] r_cycle_cnt, w_cycle_cnt_nx;

  logic             w_hit;
  logic [2:0]       w_idx;
  logic [2:0]       w_exp;
  logic             w_is_exp;
  logic [3:0]       w_match_inc;
  logic [7:0]       w_err_cnt_sat;

  // Entries are unique, so "is the expected next" reduces to an index compare.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ[i*CW +: CW] == cnt_in) begin
        w_hit = 1'b1;
        w_idx = 3'(i);
      end
    end
  end

  assign w_exp         = (r_pos == 3'(SEQ_LEN-1)) ? 3'd0 : r_pos + 3'd1;
  assign w_is_exp      = w_hit && (w_idx == w_exp);
  assign w_match_inc   = r_match + 4'd1;
  assign w_err_cnt_sat = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_comb begin
    w_state_nx      = r_state;
    w_pos_nx        = r_pos;
    w_match_nx      = r_match;
    w_err_nx        = 1'b0;
    w_illegal_nx    = 1'b0;
    w_cycle_done_nx = 1'b0;
    w_err_cnt_nx    = r_err_cnt;
    w_cycle_cnt_nx  = r_cycle_cnt;
    case (r_state)
      S_HUNT: if (valid) begin
        if (w_hit) begin
          w_state_nx = S_VERIFY;
          w_pos_nx   = w_idx;
          w_match_nx = '0;
        end else begin
          w_illegal_nx = 1'b1;
        end
      end
      S_VERIFY: if (valid) begin
        if (w_is_exp) begin
          w_pos_nx   = w_exp;
          w_match_nx = w_match_inc;
          if (w_match_inc == 4'(LOCK_THRESH)) w_state_nx = S_LOCK;
        end else if (w_hit) begin
          w_pos_nx   = w_idx;
          w_match_nx = '0;
        end else begin
          w_illegal_nx = 1'b1;
          w_state_nx   = S_HUNT;
          w_pos_nx     = '0;
          w_match_nx   = '0;
        end
      end
      S_LOCK: if (valid) begin
        if (w_is_exp) begin
          w_pos_nx = w_exp;
          if (w_exp == 3'(SEQ_LEN-1)) begin
            w_cycle_done_nx = 1'b1;
            w_cycle_cnt_nx  = r_cycle_cnt + 1'b1;
          end
        end else begin
          // Any miss in lock is an error; a legal miss re-anchors, an illegal one drops to hunt.
          w_err_nx     = 1'b1;
          w_err_cnt_nx = w_err_cnt_sat;
          w_match_nx   = '0;
          if (w_hit) begin
            w_state_nx = S_VERIFY;
            w_pos_nx   = w_idx;
          end else begin
            w_illegal_nx = 1'b1;
            w_state_nx   = S_HUNT;
            w_pos_nx     = '0;
          end
        end
      end
      default: begin
        w_state_nx = S_HUNT;
        w_pos_nx   = '0;
        w_match_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_pos        <= '0;
      r_match      <= '0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_illegal    <= 1'b0;
      r_cycle_done <= 1'b0;
      r_err_cnt    <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pos        <= w_pos_nx;
      r_match      <= w_match_nx;
      r_locked     <= (w_state_nx == S_LOCK);
      r_err        <= w_err_nx;
      r_illegal    <= w_illegal_nx;
      r_cycle_done <= w_cycle_done_nx;
      r_err_cnt    <= w_err_cnt_nx;
      r_cycle_cnt  <= w_cycle_cnt_nx;
    end
  end

  assign locked     = r_locked;
  assign pos        = r_pos;
  assign err        = r_err;
  assign illegal    = r_illegal;
  assign err_cnt    = r_err_cnt;
  assign cycle_done = r_cycle_done;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Scoreboard bench for cnt_seq_monitor: a driver pushes model predictions,
// a monitor pops and compares them one clock after each sample.
module tb_cnt_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [2:0] cnt_in = 3'd0;
  logic       locked, err, illegal, cycle_done;
  logic [2:0] pos;
  logic [7:0] err_cnt, cycle_cnt;

  cnt_seq_monitor dut (
    .clk(clk), .rst(rst), .valid(valid), .cnt_in(cnt_in),
    .locked(locked), .pos(pos), .err(err), .illegal(illegal),
    .err_cnt(err_cnt), .cycle_done(cycle_done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       lk;
    bit [2:0] p;
    bit       e;
    bit       il;
    bit [7:0] ec;
    bit       cd;
    bit [7:0] cc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: the legal cycle as a plain list; mode 0=hunt 1=verify 2=lock.
  int seq_a[6] = '{0, 1, 3, 4, 5, 7};
  int m_mode, m_pos, m_match, m_errc, m_cyc;

  function automatic int idx_of(int v);
    foreach (seq_a[i]) if (seq_a[i] == v) return i;
    return -1;
  endfunction

  function automatic int next_ok();
    return seq_a[(m_pos + 1) % 6];
  endfunction

  task automatic m_step(input bit r, input bit vl, input int v, output exp_t x);
    int k, e;
    bit fe, fi, fc;
    fe = 0; fi = 0; fc = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_match = 0; m_errc = 0; m_cyc = 0;
    end else if (vl) begin
      k = idx_of(v);
      e = (m_pos + 1) % 6;
      if (m_mode == 0) begin
        if (k < 0) fi = 1;
        else begin m_mode = 1; m_pos = k; m_match = 0; end
      end else if (m_mode == 1) begin
        if (k == e) begin
          m_pos = e; m_match++;
          if (m_match == 3) m_mode = 2;
        end else if (k >= 0) begin
          m_pos = k; m_match = 0;
        end else begin
          fi = 1; m_mode = 0; m_pos = 0; m_match = 0;
        end
      end else begin
        if (k == e) begin
          m_pos = e;
          if (e == 5) begin fc = 1; m_cyc = (m_cyc + 1) % 256; end
        end else begin
          fe = 1;
          if (m_errc < 255) m_errc++;
          m_match = 0;
          if (k >= 0) begin m_mode = 1; m_pos = k; end
          else begin fi = 1; m_mode = 0; m_pos = 0; end
        end
      end
    end
    x.lk = (m_mode == 2); x.p = 3'(m_pos); x.e = fe; x.il = fi;
    x.ec = 8'(m_errc); x.cd = fc; x.cc = 8'(m_cyc);
  endtask

  task automatic drive(input bit r, input bit vl, input int v);
    exp_t x;
    @(negedge clk);
    rst = r; valid = vl; cnt_in = 3'(v);
    m_step(r, vl, v, x);
    q.push_back(x);
  endtask

  // Monitor: each queued prediction belongs to the very next rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        #1;
        x = q.pop_front();
        total++;
        if ({locked, pos, err, illegal, err_cnt, cycle_done, cycle_cnt} !==
            {x.lk, x.p, x.e, x.il, x.ec, x.cd, x.cc}) begin
          bad++;
          $display("FAIL outputs @%0t: got lk=%b pos=%0d err=%b ill=%b ec=%0d cd=%b cc=%0d want lk=%b pos=%0d err=%b ill=%b ec=%0d cd=%b cc=%0d",
                   $time, locked, pos, err, illegal, err_cnt, cycle_done, cycle_cnt,
                   x.lk, x.p, x.e, x.il, x.ec, x.cd, x.cc);
        end
      end
    end
  end

  int vals_a[4] = '{0, 1, 3, 4};
  int vals_b[4] = '{5, 7, 0, 1};

  initial begin
    int v;
    m_mode = 0; m_pos = 0; m_match = 0; m_errc = 0; m_cyc = 0;
    drive(1, 0, 0); drive(1, 0, 0);
    // Lock-on, then a full cycle
    foreach (vals_a[i]) drive(0, 1, vals_a[i]);
    foreach (vals_b[i]) drive(0, 1, vals_b[i]);
    // Locked at pos 2, then an illegal code, then re-enter via 000
    drive(0, 1, 3); drive(0, 1, 2); drive(0, 1, 0);
    // Relock, walk to pos 2, then an out-of-order legal code and relock
    foreach (vals_a[i]) if (i > 0) drive(0, 1, vals_a[i]);
    drive(0, 1, 5); drive(0, 1, 7); drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 3);
    drive(0, 1, 5); drive(0, 1, 7); drive(0, 1, 0); drive(0, 1, 1);
    // Valid gaps with garbage on idle cycles
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) drive(0, 1, next_ok());
      else drive(0, 0, 2);
    end
    // Saturate the error counter: repeat a value, then relock
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, seq_a[m_pos]);
      for (int j = 0; j < 3; j++) drive(0, 1, next_ok());
    end
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) drive(1, $urandom_range(0, 1), $urandom_range(0, 7));
      else if (r < 15) drive(0, 0, $urandom_range(0, 7));
      else if (r < 85) drive(0, 1, next_ok());
      else drive(0, 1, $urandom_range(0, 7));
    end
    // Reset while locked with valid high
    for (int j = 0; j < 4; j++) drive(0, 1, (m_mode == 0) ? 0 : next_ok());
    v = next_ok();
    drive(1, 1, v);
    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
